mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares the SDRAM-backed `sram` controller between three requesters: ROM/file loader (write-only), video DMA fetch (read-only) and the CPU (read/write). It sits between those masters and `sram` and replaces the combinational priority mux in the top level with a sequenced req/ack transaction protocol. It adds bounded CPU starvation under heavy video load and a response timeout watchdog.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive video grants allowed while `cpu_req` is pending before the CPU is forced to win.
- TIMEOUT, 255: WAIT-state cycles without `mem_ready` before the transaction is aborted; legal range 1–255.

Ports:
- clk  in  1  system clock (clk_sys); all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ld_req  in  1  loader write request, level.
- ld_addr  in  25  loader address.
- ld_data  in  8  loader write data.
- ld_ack  out  1  one-cycle completion pulse.
- vid_req  in  1  video read request, level.
- vid_addr  in  25  video address.
- vid_ack  out  1  one-cycle pulse; `rd_data` is valid in the same cycle.
- cpu_req  in  1  CPU request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  25  CPU address.
- cpu_data  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse; `rd_data` is valid for a read.
- rd_data  out  8  read data, registered and held until the next ack.
- mem_addr  out  25  address to `sram`.
- mem_din  out  8  write data to `sram`.
- mem_we  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read strobe.
- mem_dout  in  8  read data from `sram`, valid with `mem_ready`.
- mem_ready  in  1  one-cycle completion from `sram`.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
- FSM states:
  - IDLE: sample requests; if any is asserted, latch the winner's address, data and direction into mem_addr/mem_din/dir, record the owner, and go to ISSUE.
  - ISSUE: assert exactly one of mem_we or mem_rd for one cycle, load the timer with TIMEOUT, go to WAIT.
  - WAIT: on mem_ready, register mem_dout into rd_data if the access is a read, then go to DONE. Otherwise decrement the timer; when it reaches 0, set timeout_err, load rd_data = 8'hFF on a read, and go to DONE.
  - DONE: pulse the owner's ack for one cycle, then go to IDLE.
- Requests are sampled only in IDLE. A requester holding req high in the cycle after its ack starts a new transaction with the inputs present at that time.
- Requester inputs may change freely once the owner is granted; the arbiter uses latched copies.
- Priority: ld > vid > cpu, with one exception: the CPU beats video when starve_cnt == STARVE_MAX. The loader always wins.
- starve_cnt is 3 bits and saturates at STARVE_MAX. It is updated on each IDLE grant:
  - +1 on a video grant while cpu_req = 1.
  - Cleared on a CPU grant, or in any IDLE cycle with cpu_req = 0.
  - Unchanged on a loader grant.
- Writes leave rd_data unchanged. Loader transactions are always writes; video transactions are always reads.
- mem_ready outside WAIT is ignored, with no state or data change. A late response after a timeout is therefore discarded.
- Reset values: state = IDLE; all acks, mem_we, mem_rd, busy and timeout_err = 0; rd_data = 0; mem_addr = 0; mem_din = 0; starve_cnt = 0.
- Reset asserted mid-transaction aborts it without issuing an ack. Outputs take their reset values on the next edge.

## Timing
- Request in IDLE at cycle n: strobe at n+1; earliest mem_ready at n+2; ack at n+3; back in IDLE at n+4.
- Minimum transaction period is 4 cycles. The next grant is decided at n+4.
- busy is high from n+1 through n+3 inclusive.
- The strobe is exactly 1 cycle wide, and mem_addr/mem_din are stable from n+1 until the next grant.
- Timeout: with no mem_ready, the ack arrives at n+3+TIMEOUT.
- Simultaneous ld/vid/cpu requests resolve in the same IDLE cycle. No more than one ack is ever high.

## Test plan
- CPU read, 0x00ABCD, with `sram` returning 0x5A two cycles after mem_rd → mem_rd at n+1, cpu_ack and rd_data = 0x5A at n+4, busy high for 4 cycles.
- ld_req, vid_req and cpu_req all held high → grant order ld…ld until ld_req drops. Then with STARVE_MAX = 4: vid×4, cpu, vid×4, cpu; starve_cnt never exceeds 4.
- CPU write, 0x012345 ← 0xC3 → mem_we one cycle with mem_din = 0xC3 and mem_addr = 0x012345; rd_data unchanged; cpu_ack one cycle.
- `sram` silent, TIMEOUT = 8, video read → vid_ack at n+11 with rd_data = 0xFF and timeout_err = 1. A mem_ready injected later changes nothing.
- Reset asserted during WAIT of a CPU read → no cpu_ack, state IDLE, all outputs at reset values next cycle. After reset drops, a new request completes normally.
- Spurious mem_ready pulse while IDLE, and a requester holding req through its ack → no state change from the pulse; the held req produces a second back-to-back transaction starting at n+4.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences loader, video and CPU accesses onto one sram port with starvation bound and timeout watchdog
module mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_req,
   input  logic [24:0] ld_addr,
   input  logic [7:0]  ld_data,
   output logic        ld_ack,
   input  logic        vid_req,
   input  logic [24:0] vid_addr,
   output logic        vid_ack,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   output logic        cpu_ack,
   output logic [7:0]  rd_data,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   output logic        mem_rd,
   input  logic [7:0]  mem_dout,
   input  logic        mem_ready,
   output logic        busy,
   output logic        timeout_err
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {OWN_LD, OWN_VID, OWN_CPU} owner_t;
   state_t      state, state_nx;
   owner_t      owner;
   logic        dir_we;
   logic [7:0]  timer;
   logic [2:0]  starve_cnt;
   logic        any_req, cpu_win, vid_win;
   always_comb begin
      any_req  = ld_req | vid_req | cpu_req;
      cpu_win  = !ld_req && cpu_req && (!vid_req || starve_cnt == 3'(STARVE_MAX));
      vid_win  = !ld_req && vid_req && !cpu_win;
      state_nx = state;
      case (state)
         IDLE:    state_nx = any_req ? ISSUE : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = (mem_ready || timer == 8'd0) ? DONE : WAIT;
         default: state_nx = IDLE;
      endcase
      busy    = state != IDLE;
      mem_we  = state == ISSUE && dir_we;
      mem_rd  = state == ISSUE && !dir_we;
      ld_ack  = state == DONE && owner == OWN_LD;
      vid_ack = state == DONE && owner == OWN_VID;
      cpu_ack = state == DONE && owner == OWN_CPU;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= OWN_LD;
         dir_we      <= 1'b0;
         timer       <= 8'd0;
         starve_cnt  <= 3'd0;
         mem_addr    <= 25'd0;
         mem_din     <= 8'd0;
         rd_data     <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE) begin
            // the starvation count only grows while the CPU is actually waiting behind video
            if (!cpu_req || cpu_win)
               starve_cnt <= 3'd0;
            else if (vid_win && starve_cnt != 3'(STARVE_MAX))
               starve_cnt <= starve_cnt + 3'd1;
            if (any_req) begin
               owner    <= ld_req ? OWN_LD : cpu_win ? OWN_CPU : OWN_VID;
               dir_we   <= ld_req || (cpu_win && cpu_we);
               mem_addr <= ld_req ? ld_addr : cpu_win ? cpu_addr : vid_addr;
               mem_din  <= ld_req ? ld_data : cpu_win ? cpu_data : 8'h00;
            end
         end
         if (state == ISSUE)
            timer <= 8'(TIMEOUT);
         if (state == WAIT) begin
            if (mem_ready) begin
               if (!dir_we)
                  rd_data <= mem_dout;
            end else if (timer == 8'd0) begin
               timeout_err <= 1'b1;
               if (!dir_we)
                  rd_data <= 8'hFF;
            end else
               timer <= timer - 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench with a behavioural sram responder and arbitration model
module tb_mem_arbiter;
   localparam int SM = 4;
   localparam int TO = 8;
   logic        clk = 1'b0, reset = 1'b1;
   logic        ld_req = 1'b0, vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
   logic [24:0] ld_addr = '0, vid_addr = '0, cpu_addr = '0;
   logic [7:0]  ld_data = '0, cpu_data = '0;
   logic        ld_ack, vid_ack, cpu_ack;
   logic [7:0]  rd_data;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we, mem_rd, busy, timeout_err;
   logic [7:0]  mem_dout = '0;
   logic        mem_ready = 1'b0;

   mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
      .rd_data(rd_data), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
      .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          owner;
      logic [24:0] addr;
      logic [7:0]  din;
      bit          we;
      logic [7:0]  rd;
      bit          terr;
      bit          sil;
      int          lat;
      int          n;
   } exp_t;
   exp_t exp_q[$];

   int errors = 0, checks = 0;
   logic [7:0] sram_mem[int];
   logic [7:0] ref_mem[int];
   int streak = 0;
   logic [7:0] last_rd = 8'h00;
   bit terr_m = 1'b0, after_ack = 1'b0, idle_next = 1'b0;
   int busy_cnt = 0, strobes = 0, pending = 0;
   logic [24:0] r_addr = '0;

   function automatic logic [7:0] dflt(input logic [24:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ld_ack"}, ld_ack, 0);
      chk({tag, "_vid_ack"}, vid_ack, 0);
      chk({tag, "_cpu_ack"}, cpu_ack, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_rd"}, mem_rd, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_din"}, mem_din, 0);
   endtask

   // Reference arbitration: loader first, then CPU once video has won SM times in a row over it
   task automatic issue(input bit l, v, c, we, sil, input int lat, input logic [24:0] ca, input logic [7:0] cd);
      exp_t e;
      int g;
      ld_req = l; vid_req = v; cpu_req = c; cpu_we = we; cpu_addr = ca; cpu_data = cd;
      ld_addr = 25'($urandom_range(0, 15)); ld_data = 8'($urandom); vid_addr = 25'($urandom_range(0, 15));
      if (!c) streak = 0;
      e.owner = l ? 0 : (c && (!v || streak == SM)) ? 2 : 1;
      if (e.owner == 2) streak = 0;
      else if (e.owner == 1 && c && streak < SM) streak++;
      e.we   = e.owner == 0 || (e.owner == 2 && we);
      e.addr = e.owner == 0 ? ld_addr : e.owner == 1 ? vid_addr : ca;
      e.din  = e.owner == 0 ? ld_data : cd;
      if (e.we) ref_mem[int'(e.addr)] = e.din;
      else last_rd = sil ? 8'hFF : ref_mem.exists(int'(e.addr)) ? ref_mem[int'(e.addr)] : dflt(e.addr);
      terr_m |= sil;
      e.rd = last_rd; e.terr = terr_m; e.sil = sil; e.lat = lat;
      e.n = after_ack ? cyc + 1 : cyc;
      exp_q.push_back(e);
      g = 0;
      do begin @(negedge clk); g++; end while (!busy && g < 4);
      ld_addr = 25'($urandom); ld_data = 8'($urandom); vid_addr = 25'($urandom);
      cpu_addr = 25'($urandom); cpu_data = 8'($urandom); cpu_we = 1'($urandom);
      g = 0;
      do begin @(negedge clk); g++; end while (!(ld_ack | vid_ack | cpu_ack) && g < 40);
      if (!(ld_ack | vid_ack | cpu_ack)) begin
         checks++; errors++;
         $display("FAIL ack_wait: no ack within 40 cycles (cycle %0d)", cyc);
      end
      after_ack = 1'b1;
   endtask

   task automatic gap(input int k);
      ld_req = 0; vid_req = 0; cpu_req = 0;
      repeat (k) @(negedge clk);
      after_ack = 1'b0;
      streak = 0;
   endtask

   // Monitor: pops the scoreboard on every ack
   initial begin
      exp_t e;
      int own, lat_exp;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_cnt = 0; strobes = 0;
         end else begin
            if (busy) busy_cnt++;
            if (ld_ack | vid_ack | cpu_ack) begin
               chk("ack_count", $countones({ld_ack, vid_ack, cpu_ack}), 1);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_ack: ld=%0b vid=%0b cpu=%0b with nothing outstanding", ld_ack, vid_ack, cpu_ack);
               end else begin
                  e = exp_q.pop_front();
                  own = ld_ack ? 0 : vid_ack ? 1 : 2;
                  lat_exp = e.sil ? 3 + TO : 2 + e.lat;
                  chk("ack_owner", own, e.owner);
                  chk("rd_data", rd_data, e.rd);
                  chk("timeout_err", timeout_err, e.terr);
                  chk("ack_latency", cyc - e.n, lat_exp);
                  chk("busy_cycles", busy_cnt, lat_exp);
                  chk("strobe_count", strobes, 1);
               end
               busy_cnt = 0; strobes = 0;
            end
         end
      end
   end

   // sram responder: answers strobes after the chosen latency and injects stray mem_ready around acks
   initial begin
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (reset) begin
            pending = 0; idle_next = 1'b0;
         end else begin
            if (pending > 0) begin
               pending--;
               if (pending == 0) begin
                  mem_ready = 1'b1;
                  mem_dout = sram_mem.exists(int'(r_addr)) ? sram_mem[int'(r_addr)] : dflt(r_addr);
               end
            end else if ((ld_ack | vid_ack | cpu_ack | idle_next) && $urandom_range(0, 2) == 0) begin
               mem_ready = 1'b1;
               mem_dout = 8'($urandom);
            end
            idle_next = ld_ack | vid_ack | cpu_ack;
            if (mem_rd | mem_we) begin
               strobes++;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_strobe: we=%0b rd=%0b addr=0x%0h", mem_we, mem_rd, mem_addr);
               end else begin
                  chk("strobe_dir", {mem_we, mem_rd}, exp_q[0].we ? 2'b10 : 2'b01);
                  chk("mem_addr", mem_addr, exp_q[0].addr);
                  if (exp_q[0].we) chk("mem_din", mem_din, exp_q[0].din);
                  if (!exp_q[0].sil) pending = exp_q[0].lat;
               end
               if (mem_we) sram_mem[int'(mem_addr)] = mem_din;
               r_addr = mem_addr;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      bit l, v, c;
      repeat (3) @(negedge clk);
      check_reset("por");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      sram_mem[int'(25'h00ABCD)] = 8'h5A;
      ref_mem[int'(25'h00ABCD)] = 8'h5A;
      issue(0, 0, 1, 0, 0, 2, 25'h00ABCD, 8'h00);
      gap(2);
      issue(0, 0, 1, 1, 0, 1, 25'h012345, 8'hC3);
      gap(3);
      issue(0, 1, 0, 0, 1, 1, 25'h0, 8'h0);
      issue(0, 0, 1, 1, 0, 2, 25'h000007, 8'h99);
      repeat (3) issue(1, 1, 1, 1'($urandom), 0, $urandom_range(1, 3), 25'($urandom_range(0, 15)), 8'($urandom));
      repeat (10) issue(0, 1, 1, 1'($urandom), 0, $urandom_range(1, 3), 25'($urandom_range(0, 15)), 8'($urandom));
      gap(2);
      cpu_req = 1; cpu_we = 0; cpu_addr = 25'h1F0F0F;
      e.owner = 2; e.addr = 25'h1F0F0F; e.din = 0; e.we = 0; e.rd = 8'hFF; e.terr = 1;
      e.sil = 1; e.lat = 1; e.n = cyc;
      exp_q.push_back(e);
      repeat (4) @(negedge clk);
      reset = 1'b1; cpu_req = 0;
      exp_q.delete();
      @(negedge clk);
      check_reset("mid_reset");
      reset = 1'b0;
      streak = 0; last_rd = 8'h00; terr_m = 1'b0; after_ack = 1'b0;
      @(negedge clk);
      issue(0, 0, 1, 0, 0, 1, 25'h00ABCD, 8'h00);
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 5) == 0) gap($urandom_range(2, 4));
         l = $urandom_range(0, 4) == 0;
         v = 1'($urandom_range(0, 1));
         c = 1'($urandom_range(0, 1));
         if (!l && !v && !c) c = 1;
         issue(l, v, c, 1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(1, 3),
               25'($urandom_range(0, 15)), 8'($urandom));
      end
      gap(4);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
